alu_seq: RTL

Parametrised, registered successor to the single-cycle PIC core ALU. It executes the existing ALU function set at any DATA_WIDTH and adds an iterative unsigned multiply (MULWF/MULLW).
- Operand input and result output each use a valid/ready handshake, so the core controller can stall on either side.
- Status flags {Z, DC, C} are registered and returned with a per-flag write-enable mask, so the status register update is explicit.

---
 rtl/alu_seq_pkg.sv | 38 +++
 rtl/alu_seq_mul.sv | 50 +++++
 rtl/alu_seq.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/alu_seq_pkg.sv
// Shared function encoding, flag indices and FSM states
// for the registered PIC ALU.
package alu_seq_pkg;

   localparam int FUNC_WIDTH   = 5;
   localparam int STATUS_WIDTH = 3;

   localparam int FLAG_Z  = 2;
   localparam int FLAG_DC = 1;
   localparam int FLAG_C  = 0;

   localparam logic [4:0] ALU_ADDWF = 5'h00;
   localparam logic [4:0] ALU_SUBWF = 5'h01;
   localparam logic [4:0] ALU_ANDWF = 5'h02;
   localparam logic [4:0] ALU_IORWF = 5'h03;
   localparam logic [4:0] ALU_XORWF = 5'h04;
   localparam logic [4:0] ALU_COMF  = 5'h05;
   localparam logic [4:0] ALU_INCF  = 5'h06;
   localparam logic [4:0] ALU_DECF  = 5'h07;
   localparam logic [4:0] ALU_RLF   = 5'h08;
   localparam logic [4:0] ALU_RRF   = 5'h09;
   localparam logic [4:0] ALU_SWAPF = 5'h0A;
   localparam logic [4:0] ALU_BCF   = 5'h0B;
   localparam logic [4:0] ALU_BSF   = 5'h0C;
   localparam logic [4:0] ALU_ADDLW = 5'h0D;
   localparam logic [4:0] ALU_SUBLW = 5'h0E;
   localparam logic [4:0] ALU_ANDLW = 5'h0F;
   localparam logic [4:0] ALU_IORLW = 5'h10;
   localparam logic [4:0] ALU_XORLW = 5'h11;
   localparam logic [4:0] ALU_MULWF = 5'h12;
   localparam logic [4:0] ALU_MULLW = 5'h13;

   typedef enum logic {
      ST_IDLE,
      ST_MUL
   } state_e;

endpackage

// File: rtl/alu_seq_mul.sv
// Iterative shift-add unsigned multiplier, one multiplier
// bit per cycle; product is valid combinationally with done.
module alu_seq_mul #(
   parameter int DATA_WIDTH = 8
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      start,
   input  logic [DATA_WIDTH-1:0]     a,
   input  logic [DATA_WIDTH-1:0]     b,
   output logic                      done,
   output logic [2*DATA_WIDTH-1:0]   product
);

   localparam int DW = DATA_WIDTH;
   localparam int CW = $clog2(DW);

   logic          busy;
   logic [CW-1:0] cnt;
   logic [2*DW-1:0] acc;
   logic [2*DW-1:0] mcand;
   logic [DW-1:0] mplier;

   // product includes the bit processed this cycle
   assign product = acc + (mplier[0] ? mcand : '0);
   assign done    = busy && (cnt == '0);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy   <= 1'b0;
         cnt    <= '0;
         acc    <= '0;
         mcand  <= '0;
         mplier <= '0;
      end else if (start) begin
         busy   <= 1'b1;
         cnt    <= CW'(DW - 1);
         acc    <= '0;
         mcand  <= {{DW{1'b0}}, a};
         mplier <= b;
      end else if (busy) begin
         acc    <= product;
         mcand  <= mcand << 1;
         mplier <= mplier >> 1;
         cnt    <= cnt - CW'(1);
         if (done) busy <= 1'b0;
      end
   end

endmodule

// File: rtl/alu_seq.sv
// Registered PIC ALU with valid/ready handshakes on both
// sides and an iterative MUL path.
module alu_seq #(
   parameter int DATA_WIDTH   = 8,
   parameter int FUNC_WIDTH   = alu_seq_pkg::FUNC_WIDTH,
   parameter int STATUS_WIDTH = alu_seq_pkg::STATUS_WIDTH
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic [DATA_WIDTH-1:0]         wIn,
   input  logic [DATA_WIDTH-1:0]         fIn,
   input  logic [DATA_WIDTH-1:0]         lIn,
   input  logic [FUNC_WIDTH-1:0]         funcIn,
   input  logic [$clog2(DATA_WIDTH)-1:0] bitSel,
   input  logic [STATUS_WIDTH-1:0]       statusIn,
   input  logic                          inValid,
   output logic                          inReady,
   output logic                          outValid,
   input  logic                          outReady,
   output logic [DATA_WIDTH-1:0]         resultOut,
   output logic [DATA_WIDTH-1:0]         resultHiOut,
   output logic [STATUS_WIDTH-1:0]       statusOut,
   output logic [STATUS_WIDTH-1:0]       statusWe,
   output logic                          illegalOut
);
   import alu_seq_pkg::*;

   localparam int DW = DATA_WIDTH;
   localparam logic [DW-1:0] ONE_W = {{(DW-1){1'b0}}, 1'b1};

   state_e state, state_nxt;

   logic          accept;
   logic          is_mul;
   logic          ill;
   logic          c, dc;
   logic [DW-1:0] res;
   logic [STATUS_WIDTH-1:0] we;
   logic [DW-1:0] opa;
   logic [DW:0]   sum, dif;
   logic [4:0]    nib_add, nib_sub;
   logic [1:0]    sin_q;
   logic          mul_done;
   logic [2*DW-1:0] prod;
   logic [DW-1:0] mul_b;
   logic          unused_z;

   assign unused_z = statusIn[FLAG_Z];
   assign accept   = inValid && inReady;

   assign opa = (funcIn == ALU_ADDLW || funcIn == ALU_SUBLW) ? lIn : fIn;
   assign sum = {1'b0, opa} + {1'b0, wIn};
   assign dif = {1'b0, opa} + {1'b0, ~wIn} + {{DW{1'b0}}, 1'b1};
   assign nib_add = {1'b0, opa[3:0]} + {1'b0, wIn[3:0]};
   assign nib_sub = {1'b0, opa[3:0]} + {1'b0, ~wIn[3:0]} + 5'd1;

   always_comb begin
      res    = '0;
      c      = statusIn[FLAG_C];
      dc     = statusIn[FLAG_DC];
      we     = '0;
      ill    = 1'b0;
      is_mul = 1'b0;
      unique case (funcIn)
         ALU_ADDWF, ALU_ADDLW: begin
            {c, res} = sum; dc = nib_add[4]; we = 3'b111;
         end
         ALU_SUBWF, ALU_SUBLW: begin
            {c, res} = dif; dc = nib_sub[4]; we = 3'b111;
         end
         ALU_ANDWF: begin res = fIn & wIn; we = 3'b100; end
         ALU_IORWF: begin res = fIn | wIn; we = 3'b100; end
         ALU_XORWF: begin res = fIn ^ wIn; we = 3'b100; end
         ALU_ANDLW: begin res = lIn & wIn; we = 3'b100; end
         ALU_IORLW: begin res = lIn | wIn; we = 3'b100; end
         ALU_XORLW: begin res = lIn ^ wIn; we = 3'b100; end
         ALU_COMF:  begin res = ~fIn; we = 3'b100; end
         ALU_INCF:  begin res = fIn + ONE_W; we = 3'b100; end
         ALU_DECF:  begin res = fIn - ONE_W; we = 3'b100; end
         ALU_RLF: begin
            {c, res} = {fIn, statusIn[FLAG_C]}; we = 3'b001;
         end
         ALU_RRF: begin
            {res, c} = {statusIn[FLAG_C], fIn}; we = 3'b001;
         end
         ALU_SWAPF: res = {fIn[DW/2-1:0], fIn[DW-1:DW/2]};
         ALU_BCF: begin res = fIn; res[bitSel] = 1'b0; end
         ALU_BSF: begin res = fIn; res[bitSel] = 1'b1; end
         ALU_MULWF, ALU_MULLW: is_mul = 1'b1;
         default: ill = 1'b1;
      endcase
   end

   assign mul_b = (funcIn == ALU_MULLW) ? lIn : fIn;

   alu_seq_mul #(.DATA_WIDTH(DW)) u_mul (
      .clk     (clk),
      .rst_n   (rst_n),
      .start   (accept && is_mul),
      .a       (wIn),
      .b       (mul_b),
      .done    (mul_done),
      .product (prod)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= ST_IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         ST_IDLE: if (accept && is_mul) state_nxt = ST_MUL;
         ST_MUL:  if (mul_done) state_nxt = ST_IDLE;
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_comb begin
      inReady = (state == ST_IDLE) && (!outValid || outReady);
   end

   // DC/C seen at MUL accept are echoed when the product lands
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         outValid    <= 1'b0;
         resultOut   <= '0;
         resultHiOut <= '0;
         statusOut   <= '0;
         statusWe    <= '0;
         illegalOut  <= 1'b0;
         sin_q       <= '0;
      end else begin
         if (accept && is_mul)
            sin_q <= {statusIn[FLAG_DC], statusIn[FLAG_C]};
         if (accept && !is_mul) begin
            outValid    <= 1'b1;
            resultOut   <= res;
            resultHiOut <= '0;
            statusOut   <= {res == '0, dc, c};
            statusWe    <= we;
            illegalOut  <= ill;
         end else if (mul_done) begin
            outValid    <= 1'b1;
            resultOut   <= prod[DW-1:0];
            resultHiOut <= prod[2*DW-1:DW];
            statusOut   <= {prod == '0, sin_q};
            statusWe    <= '0;
            illegalOut  <= 1'b0;
         end else if (outValid && outReady) begin
            outValid    <= 1'b0;
            resultOut   <= '0;
            resultHiOut <= '0;
            statusOut   <= '0;
            statusWe    <= '0;
            illegalOut  <= 1'b0;
         end
      end
   end

endmodule
